quadrilatero_skew_ctrl: RTL and testbench

QUADRILATERO_SKEW_CTRL -- requirements
Module: quadrilatero_skew_ctrl

---
 rtl/quadrilatero_skew_pkg.sv | 19 +
 rtl/quadrilatero_skew_ctrl.sv | 147 ++++++++++++++
 tb/tb_quadrilatero_skew_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/quadrilatero_skew_pkg.sv
// Shared types and sizing helpers for the quadrilatero skew controller.
package quadrilatero_skew_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } skew_state_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val == 32'd0) begin
      return 32'd1;
    end else begin
      return $clog2(max_val + 32'd1);
    end
  endfunction

endpackage

// File: rtl/quadrilatero_skew_ctrl.sv
// Feeds k rows into the mesh skewer, then drains MESH_WIDTH-1 zero rows.
// Optional stall counter is built only with QUADRILATERO_SKEW_PERF_EN defined.
module quadrilatero_skew_ctrl
  import quadrilatero_skew_pkg::*;
#(
  parameter int unsigned MESH_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned K_MAX      = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  start_i,
  input  logic [$clog2(K_MAX+1)-1:0]            k_i,
  input  logic                                  row_valid_i,
  output logic                                  row_ready_o,
  input  logic [MESH_WIDTH-1:0][DATA_WIDTH-1:0] row_i,
  input  logic                                  mesh_ready_i,
  output logic                                  pump_o,
  output logic [MESH_WIDTH-1:0][DATA_WIDTH-1:0] skew_data_o,
  output logic                                  mesh_valid_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic [31:0]                           stall_cnt_o
);

  localparam int unsigned KW = $clog2(K_MAX + 1);
  localparam int unsigned DW = cnt_width(MESH_WIDTH);

  skew_state_e   state_r, state_s;
  logic [KW-1:0] k_r, k_s;
  logic [KW-1:0] row_cnt_r, row_cnt_s;
  logic [DW-1:0] drain_cnt_r, drain_cnt_s;
  logic          done_r, done_s;
  logic          start_acc_s;

  // Next-state, handshake and skewer drive for the feed/drain sequence.
  always_comb begin
    state_s     = state_r;
    k_s         = k_r;
    row_cnt_s   = row_cnt_r;
    drain_cnt_s = drain_cnt_r;
    done_s      = 1'b0;
    start_acc_s = 1'b0;
    row_ready_o = 1'b0;
    pump_o      = 1'b0;
    skew_data_o = '0;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          start_acc_s = 1'b1;
          if (k_i != '0) begin
            state_s   = FEED;
            k_s       = k_i;
            row_cnt_s = '0;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FEED: begin
        row_ready_o = mesh_ready_i;
        // Without a handshake the skewer stays frozen to keep diagonals aligned.
        if (row_valid_i && mesh_ready_i) begin
          pump_o      = 1'b1;
          skew_data_o = row_i;
          row_cnt_s   = row_cnt_r + KW'(1);
          if ((row_cnt_r + KW'(1)) == k_r) begin
            if (MESH_WIDTH == 1) begin
              state_s = IDLE;
              done_s  = 1'b1;
            end else begin
              state_s     = DRAIN;
              drain_cnt_s = DW'(MESH_WIDTH - 1);
            end
          end else begin
            state_s = FEED;
          end
        end else begin
          pump_o = 1'b0;
        end
      end
      DRAIN: begin
        if (mesh_ready_i) begin
          pump_o      = 1'b1;
          drain_cnt_s = drain_cnt_r - DW'(1);
          if (drain_cnt_r == DW'(1)) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = DRAIN;
          end
        end else begin
          drain_cnt_s = drain_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, latched k, counters and the registered completion pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      k_r         <= '0;
      row_cnt_r   <= '0;
      drain_cnt_r <= '0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      k_r         <= k_s;
      row_cnt_r   <= row_cnt_s;
      drain_cnt_r <= drain_cnt_s;
      done_r      <= done_s;
    end
  end

  assign mesh_valid_o = pump_o;
  assign busy_o       = (state_r != IDLE);
  assign done_o       = done_r;

`ifdef QUADRILATERO_SKEW_PERF_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of feed cycles where the mesh was ready but no row came.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_r <= 32'd0;
    end else if (start_acc_s) begin
      stall_cnt_r <= 32'd0;
    end else if ((state_r == FEED) && mesh_ready_i && !row_valid_i &&
                 (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_quadrilatero_skew_ctrl.sv
// Directed bench for quadrilatero_skew_ctrl (MESH_WIDTH=4, DATA_WIDTH=32, K_MAX=16).
module tb_quadrilatero_skew_ctrl;

  localparam int MW  = 4;
  localparam int DWD = 32;
  localparam int KW  = 5;

`ifdef QUADRILATERO_SKEW_PERF_EN
  localparam logic [31:0] EXP_STALL_GAP = 32'd2;
`else
  localparam logic [31:0] EXP_STALL_GAP = 32'd0;
`endif

  logic                       clk = 1'b0;
  logic                       rst_ni;
  logic                       start_i;
  logic [KW-1:0]              k_i;
  logic                       row_valid_i;
  logic                       row_ready_o;
  logic [MW-1:0][DWD-1:0]     row_i;
  logic                       mesh_ready_i;
  logic                       pump_o;
  logic [MW-1:0][DWD-1:0]     skew_data_o;
  logic                       mesh_valid_o;
  logic                       busy_o;
  logic                       done_o;
  logic [31:0]                stall_cnt_o;

  int total = 0;
  int bad   = 0;

  quadrilatero_skew_ctrl #(.MESH_WIDTH(MW), .DATA_WIDTH(DWD), .K_MAX(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .k_i(k_i),
    .row_valid_i(row_valid_i), .row_ready_o(row_ready_o), .row_i(row_i),
    .mesh_ready_i(mesh_ready_i), .pump_o(pump_o), .skew_data_o(skew_data_o),
    .mesh_valid_o(mesh_valid_o), .busy_o(busy_o), .done_o(done_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [MW*DWD-1:0] mk_row(input int c);
    logic [MW-1:0][DWD-1:0] r;
    for (int l = 0; l < MW; l++) r[l] = 32'hA500_0000 + 32'(c * 16 + l);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: per-cycle stimulus bits and hand-derived expectation bits.
  task automatic run(input string tag, input int k0, input int k2, input int n,
                     input logic [31:0] spat, input logic [31:0] vpat, input logic [31:0] rpat,
                     input logic [31:0] ppat, input logic [31:0] dpat, input logic [31:0] fpat,
                     input logic [31:0] bpat, input int done_cyc, input int exp_total);
    int pumps = 0;
    for (int c = 0; c < n; c++) begin
      start_i      = spat[c];
      k_i          = (c == 0) ? KW'(k0) : KW'(k2);
      row_valid_i  = vpat[c];
      mesh_ready_i = rpat[c];
      row_i        = mk_row(c);
      #2;
      chk($sformatf("%s/pump c%0d", tag, c), 128'(pump_o), 128'(ppat[c]));
      chk($sformatf("%s/mvalid c%0d", tag, c), 128'(mesh_valid_o), 128'(ppat[c]));
      chk($sformatf("%s/ready c%0d", tag, c), 128'(row_ready_o), 128'(fpat[c] & rpat[c]));
      chk($sformatf("%s/busy c%0d", tag, c), 128'(busy_o), 128'(bpat[c]));
      chk($sformatf("%s/done c%0d", tag, c), 128'(done_o), 128'(c == done_cyc));
      chk($sformatf("%s/data c%0d", tag, c), 128'(skew_data_o),
          (ppat[c] & dpat[c]) ? 128'(mk_row(c)) : 128'd0);
      if (pump_o) pumps++;
      @(posedge clk); #2;
    end
    start_i     = 1'b0;
    row_valid_i = 1'b0;
    chk({tag, "/pump_total"}, 128'(pumps), 128'(exp_total));
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; k_i = '0; row_valid_i = 1'b1; mesh_ready_i = 1'b1;
    row_i = mk_row(99);
    #2;
    chk("rst/pump", 128'(pump_o), 128'd0);
    chk("rst/ready", 128'(row_ready_o), 128'd0);
    chk("rst/busy", 128'(busy_o), 128'd0);
    chk("rst/done", 128'(done_o), 128'd0);
    chk("rst/stall", 128'(stall_cnt_o), 128'd0);
    chk("rst/data", 128'(skew_data_o), 128'd0);
    @(posedge clk); #2;
    rst_ni = 1'b1; row_valid_i = 1'b0;
    @(posedge clk); #2;

    // k=4, free flow: 7 pumps, done 8 cycles after start
    run("full", 4, 4, 10, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h0FE, 32'h01E, 32'h01E, 32'h0FE, 8, 7);
    // k=3, two starved cycles after row 1
    run("gap", 3, 3, 11, 32'h1, 32'hFFFF_FFF3, 32'hFFFF_FFFF,
        32'h1F2, 32'h032, 32'h03E, 32'h1FE, 9, 6);
    chk("gap/stall", 128'(stall_cnt_o), 128'(EXP_STALL_GAP));
    // k=2, mesh stalls three cycles in the drain
    run("drain_hold", 2, 2, 11, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FF8F,
        32'h18E, 32'h006, 32'h006, 32'h1FE, 9, 5);
    chk("drain_hold/stall_cleared", 128'(stall_cnt_o), 128'd0);
    // k=0: immediate done, never busy
    run("k0", 0, 0, 3, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
    // starts while busy (k_i=1) are ignored
    run("busy_start", 3, 1, 9, 32'h45, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h07E, 32'h00E, 32'h00E, 32'h07E, 7, 6);

    // Reset after two of four rows
    start_i = 1'b1; k_i = KW'(4); row_valid_i = 1'b1; mesh_ready_i = 1'b1; row_i = mk_row(1);
    @(posedge clk); #2;
    start_i = 1'b0;
    #2; chk("abort/pump1", 128'(pump_o), 128'd1);
    @(posedge clk); #2;
    #2; chk("abort/pump2", 128'(pump_o), 128'd1);
    @(posedge clk); #2;
    #1 rst_ni = 1'b0;
    #1;
    chk("abort/pump", 128'(pump_o), 128'd0);
    chk("abort/mvalid", 128'(mesh_valid_o), 128'd0);
    chk("abort/ready", 128'(row_ready_o), 128'd0);
    chk("abort/busy", 128'(busy_o), 128'd0);
    chk("abort/done", 128'(done_o), 128'd0);
    chk("abort/stall", 128'(stall_cnt_o), 128'd0);
    chk("abort/data", 128'(skew_data_o), 128'd0);
    @(posedge clk); #2;
    rst_ni = 1'b1; row_valid_i = 1'b0;
    @(posedge clk); #2;
    chk("abort/no_done", 128'(done_o), 128'd0);
    chk("abort/idle", 128'(busy_o), 128'd0);
    run("restart", 4, 4, 10, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h0FE, 32'h01E, 32'h01E, 32'h0FE, 8, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
